// File: rtl/mod_exp_pkg.sv
// Shared definitions for the Montgomery modular exponentiator: FSM states,
// default widths and the digit-count helper.
package mod_exp_pkg;

  localparam int N_W_DEF    = 256;
  localparam int E_W_DEF    = 32;
  localparam int WORD_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    CONV_X,
    CONV_A,
    SQR,
    MUL,
    FROM_MONT,
    DONE
  } state_t;

  function automatic int num_digits(input int n_w, input int word_w);
    return n_w / word_w;
  endfunction

endpackage

// File: rtl/mont_mul.sv
// Digit-serial Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^N_W.
// Operand b and the modulus are assumed below n; a may be any N_W-bit value.
module mont_mul
  import mod_exp_pkg::*;
#(
  parameter int N_W    = N_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    a,
  input  logic [N_W-1:0]    b,
  input  logic [N_W-1:0]    modulus,
  input  logic [WORD_W-1:0] n_prime,
  output logic              done,
  output logic [N_W-1:0]    result
);

  localparam int K     = num_digits(N_W, WORD_W);
  localparam int T_W   = N_W + WORD_W + 2;
  localparam int CNT_W = (K > 1) ? $clog2(K + 1) : 1;

  logic [N_W-1:0]    a_sh;
  logic [N_W-1:0]    b_r;
  logic [N_W-1:0]    n_r;
  logic [WORD_W-1:0] np_r;
  logic [T_W-1:0]    t_r;
  logic [CNT_W-1:0]  cnt;
  logic              run;

  logic [T_W-1:0]    t_sum;
  logic [WORD_W-1:0] m;
  logic [T_W-1:0]    t_red;

  // One Montgomery digit step; T stays below 2n so T_W bits never overflow.
  always_comb begin
    t_sum = t_r + T_W'(a_sh[WORD_W-1:0]) * T_W'(b_r);
    m     = t_sum[WORD_W-1:0] * np_r;
    t_red = (t_sum + T_W'(m) * T_W'(n_r)) >> WORD_W;
  end

  // The final conditional subtraction happens in the cycle done is high.
  assign result = N_W'((t_r >= T_W'(n_r)) ? (t_r - T_W'(n_r)) : t_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_r  <= '0;
      n_r  <= '0;
      np_r <= '0;
      t_r  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_sh <= a;
        b_r  <= b;
        n_r  <= modulus;
        np_r <= n_prime;
        t_r  <= '0;
        cnt  <= '0;
        run  <= 1'b1;
      end else if (run) begin
        t_r  <= t_red;
        a_sh <= a_sh >> WORD_W;
        cnt  <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(K - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_exp_mont.sv
// Left-to-right square-and-multiply modular exponentiation over mont_mul.
// Optional MODEXP_LZ_SKIP_EN skips the squarings for leading zero exponent bits.
module mod_exp_mont
  import mod_exp_pkg::*;
#(
  parameter int N_W    = N_W_DEF,
  parameter int E_W    = E_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    base,
  input  logic [E_W-1:0]    exponent,
  input  logic [N_W-1:0]    modulus,
  input  logic [WORD_W-1:0] n_prime,
  input  logic [N_W-1:0]    r2,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_W-1:0]    result
);

  localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;

  state_t            state;
  logic [E_W-1:0]    exp_r;
  logic [IDX_W-1:0]  bit_idx;
  logic [N_W-1:0]    acc;
  logic [N_W-1:0]    x_r;
  logic [N_W-1:0]    mod_r;
  logic [N_W-1:0]    r2_r;
  logic [WORD_W-1:0] np_r;
  logic [N_W-1:0]    mm_a;
  logic [N_W-1:0]    mm_b;
  logic              mm_start;
  logic              mm_done;
  logic [N_W-1:0]    mm_res;

  mont_mul #(.N_W(N_W), .WORD_W(WORD_W)) u_mont (
    .clk     (clk),
    .rst     (rst),
    .start   (mm_start),
    .a       (mm_a),
    .b       (mm_b),
    .modulus (mod_r),
    .n_prime (np_r),
    .done    (mm_done),
    .result  (mm_res)
  );

`ifdef MODEXP_LZ_SKIP_EN
  logic [IDX_W-1:0] lz_msb;

  always_comb begin
    lz_msb = '0;
    for (int i = 0; i < E_W; i++) begin
      if (exp_r[i]) lz_msb = IDX_W'(i);
    end
  end
`endif

  // Each op's result is captured in the cycle mont_mul reports done, and the
  // next op is dispatched from the same edge so ops run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exp_r    <= '0;
      bit_idx  <= '0;
      acc      <= '0;
      x_r      <= '0;
      mod_r    <= '0;
      r2_r     <= '0;
      np_r     <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_r  <= exponent;
            mod_r  <= modulus;
            np_r   <= n_prime;
            r2_r   <= r2;
            result <= '0;
            err    <= ~modulus[0];
            if (!modulus[0]) begin
              done <= 1'b1;
            end else begin
              mm_a     <= base;
              mm_b     <= r2;
              mm_start <= 1'b1;
              busy     <= 1'b1;
              state    <= CONV_X;
            end
          end
        end
        CONV_X: begin
          if (mm_done) begin
            x_r      <= mm_res;
            mm_a     <= N_W'(1);
            mm_b     <= r2_r;
            mm_start <= 1'b1;
            state    <= CONV_A;
          end
        end
        CONV_A: begin
          if (mm_done) begin
            acc      <= mm_res;
            mm_a     <= mm_res;
            mm_start <= 1'b1;
`ifdef MODEXP_LZ_SKIP_EN
            if (exp_r == '0) begin
              mm_b  <= N_W'(1);
              state <= FROM_MONT;
            end else begin
              bit_idx <= lz_msb;
              mm_b    <= mm_res;
              state   <= SQR;
            end
`else
            bit_idx <= IDX_W'(E_W - 1);
            mm_b    <= mm_res;
            state   <= SQR;
`endif
          end
        end
        SQR: begin
          if (mm_done) begin
            acc      <= mm_res;
            mm_a     <= mm_res;
            mm_start <= 1'b1;
            if (exp_r[bit_idx]) begin
              mm_b  <= x_r;
              state <= MUL;
            end else if (bit_idx == '0) begin
              mm_b  <= N_W'(1);
              state <= FROM_MONT;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
              mm_b    <= mm_res;
            end
          end
        end
        MUL: begin
          if (mm_done) begin
            acc      <= mm_res;
            mm_a     <= mm_res;
            mm_start <= 1'b1;
            if (bit_idx == '0) begin
              mm_b  <= N_W'(1);
              state <= FROM_MONT;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
              mm_b    <= mm_res;
              state   <= SQR;
            end
          end
        end
        FROM_MONT: begin
          if (mm_done) begin
            acc   <= mm_res;
            state <= DONE;
          end
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
